fetch_unit: RTL

Instruction fetch stage for the nRISC processor. Owns the program counter, drives the address into the instruction memory (`mem_instr`, 8-bit address, 8-bit data, one-clock registered read), and tracks the one-cycle read latency. Delivers each fetched instruction with its address to decode over a valid/stall handshake, with no instruction lost or duplicated. Handles taken branches and halts when the PC leaves the program window.

---
 rtl/fetch_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage for the nRISC processor.
// Owns the PC, tracks the one-clock registered read of mem_instr, and hands
// (instruction, address) pairs to decode over a valid/stall handshake using
// a one-entry skid buffer so that nothing is lost or duplicated.
// Optional feature macro: FETCH_COUNT_EN adds the 16-bit fetch_count output.
module fetch_unit #(
    parameter logic [7:0] PROG_BASE = 8'h80,
    parameter logic [7:0] PROG_LAST = 8'h99
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [7:0]  branch_target,
    output logic [7:0]  PC,
    input  logic [7:0]  instrucao,
    output logic [7:0]  instr_out,
    output logic [7:0]  instr_pc,
    output logic        instr_valid,
`ifdef FETCH_COUNT_EN
    output logic [15:0] fetch_count,
`endif
    output logic        halted
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t     state_reg;

    // Tag for the data arriving on instrucao this cycle.
    logic       m_v;
    logic [7:0] m_pc;

    // One-entry skid buffer, filled when decode stalls with a read in flight.
    logic       s_v;
    logic [7:0] s_data;
    logic [7:0] s_pc;

    logic       pc_in_window;
    logic       target_in_window;
    logic       issue;
    logic       out_free;

    assign pc_in_window     = (PC >= PROG_BASE) && (PC <= PROG_LAST);
    assign target_in_window = (branch_target >= PROG_BASE) && (branch_target <= PROG_LAST);

    // A new fetch only goes out when decode can take the stream and no redirect is pending.
    assign issue    = (state_reg == RUN) && !stall && !branch_taken && pc_in_window;

    // The output register may be overwritten when empty or being consumed.
    assign out_free = !instr_valid || !stall;

    // PC, in-flight tag, skid buffer, output register and run/drain/halt FSM.
    always_ff @(posedge clock) begin
        if (reset) begin
            PC          <= PROG_BASE;
            m_v         <= 1'b0;
            m_pc        <= 8'h00;
            s_v         <= 1'b0;
            s_data      <= 8'h00;
            s_pc        <= 8'h00;
            instr_out   <= 8'h00;
            instr_pc    <= 8'h00;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            state_reg   <= RUN;
        end else if (branch_taken) begin
            // Redirect wins over everything: flush every stage and restart at the target.
            PC          <= branch_target;
            m_v         <= 1'b0;
            s_v         <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            state_reg   <= target_in_window ? RUN : DRAIN;
        end else begin
            if (issue) begin
                m_v  <= 1'b1;
                m_pc <= PC;
                PC   <= PC + 8'd1;
            end else begin
                m_v  <= 1'b0;
            end

            if (out_free) begin
                // Skid entry is always older than anything in flight, so it goes first.
                if (s_v) begin
                    instr_out   <= s_data;
                    instr_pc    <= s_pc;
                    instr_valid <= 1'b1;
                    s_v         <= 1'b0;
                end else if (m_v) begin
                    instr_out   <= instrucao;
                    instr_pc    <= m_pc;
                    instr_valid <= 1'b1;
                end else begin
                    instr_valid <= 1'b0;
                end
            end else if (m_v) begin
                // Decode is holding the output; park the returning read.
                s_v    <= 1'b1;
                s_data <= instrucao;
                s_pc   <= m_pc;
            end

            case (state_reg)
                RUN: begin
                    if (!pc_in_window) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!m_v && !s_v && !instr_valid) begin
                        state_reg <= HALT;
                        halted    <= 1'b1;
                    end
                end
                HALT: begin
                    state_reg <= HALT;
                end
                default: begin
                    state_reg <= RUN;
                end
            endcase
        end
    end

`ifdef FETCH_COUNT_EN
    // Count instructions accepted by decode; survives branches, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_count <= 16'h0000;
        end else if (instr_valid && !stall) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end
`endif

endmodule
